// File: rtl/adder_pipe_n_if.sv
// Handshake/operand bundle for adder_pipe_n: operand beat in, result beat out.
interface adder_pipe_n_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_n.sv
// Carry-chain pipelined N-bit adder/subtractor, one CHUNK-bit slice per stage.
// Optional macro ADDER_PIPE_SAT_EN saturates s to the signed extreme on overflow.
module adder_pipe_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic           clk,
  input logic           rst,
  adder_pipe_n_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             adv_c;
  logic             last_vld;
  logic             last_cy;
  logic [WIDTH-1:0] s_q;
  logic             ovf_q;

  // Global stall: every stage moves together or holds together
  assign adv_c         = !last_vld || bus.out_ready;
  assign bus.in_ready  = adv_c;
  assign bus.out_valid = last_vld;
  assign bus.s         = s_q;
  assign bus.cout      = last_cy;
  assign bus.ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned OP_W = WIDTH - k * CHUNK;

    logic [OP_W-1:0]  a_op_c;
    logic [OP_W-1:0]  b_op_c;
    logic             c_in_c;
    logic             v_in_c;
    logic [CHUNK:0]   sum_c;
    logic             vld_q;
    logic             cy_q;

    // Stage 0 takes the bus directly; later stages take the skewed upper slices
    if (k == 0) begin : g_src
      assign a_op_c = bus.a;
      assign b_op_c = bus.b ^ {WIDTH{bus.sub}};
      assign c_in_c = bus.cin;
      assign v_in_c = bus.in_valid;
    end else begin : g_src
      assign a_op_c = g_st[k-1].g_keep.a_q;
      assign b_op_c = g_st[k-1].g_keep.b_q;
      assign c_in_c = g_st[k-1].cy_q;
      assign v_in_c = g_st[k-1].vld_q;
    end

    assign sum_c = {1'b0, a_op_c[CHUNK-1:0]} + {1'b0, b_op_c[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in_c};

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
      end else if (adv_c) begin
        vld_q <= v_in_c;
        cy_q  <= sum_c[CHUNK];
      end
    end

    if (k < STAGES - 1) begin : g_keep
      localparam int unsigned LO_W = (k + 1) * CHUNK;
      localparam int unsigned UP_W = OP_W - CHUNK;

      logic [UP_W-1:0] a_q;
      logic [UP_W-1:0] b_q;
      logic [LO_W-1:0] r_q;
      logic [LO_W-1:0] r_next_c;

      if (k == 0) begin : g_lo
        assign r_next_c = sum_c[CHUNK-1:0];
      end else begin : g_lo
        assign r_next_c = {sum_c[CHUNK-1:0], g_st[k-1].g_keep.r_q};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
        end else if (adv_c) begin
          a_q <= a_op_c[OP_W-1:CHUNK];
          b_q <= b_op_c[OP_W-1:CHUNK];
          r_q <= r_next_c;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] s_full_c;
      logic [WIDTH-1:0] s_sel_c;
      logic             ovf_c;

      if (k == 0) begin : g_lo
        assign s_full_c = sum_c[CHUNK-1:0];
      end else begin : g_lo
        assign s_full_c = {sum_c[CHUNK-1:0], g_st[k-1].g_keep.r_q};
      end

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit
      assign ovf_c = a_op_c[CHUNK-1] ^ b_op_c[CHUNK-1]
                   ^ sum_c[CHUNK-1] ^ sum_c[CHUNK];

`ifdef ADDER_PIPE_SAT_EN
      assign s_sel_c = !ovf_c ? s_full_c :
                       a_op_c[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign s_sel_c = s_full_c;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          s_q   <= '0;
          ovf_q <= 1'b0;
        end else if (adv_c) begin
          s_q   <= s_sel_c;
          ovf_q <= ovf_c;
        end
      end
    end
  end

  assign last_vld = g_st[STAGES-1].vld_q;
  assign last_cy  = g_st[STAGES-1].cy_q;
endmodule
